// File: rtl/logo_motion_pkg.sv
// Shared screen geometry and FSM encoding for the logo motion controller and graphics block.
package logo_motion_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int WIDTH_LOGO  = 80;
  localparam int HEIGHT_LOGO = 96;
  localparam int POS_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/logo_motion_axis_bounce.sv
// One axis of the bouncing motion: steps the position and reflects off either wall.
module axis_bounce
  import logo_motion_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 80,
  parameter int STEP  = 1
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  output logic [POS_W-1:0] next_pos,
  output logic             next_dir,
  output logic             hit
);

  // 11-bit headroom so pos+SIZE+STEP never wraps.
  logic [POS_W:0] pos_w;
  assign pos_w = {1'b0, pos};

  // Forward step clamps to the far wall when it would overshoot; backward clamps to 0.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir) begin
      if (pos_w + 11'(SIZE) + 11'(STEP) > 11'(LIMIT)) begin
        next_pos = 10'(LIMIT - SIZE);
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = 10'(pos_w + 11'(STEP));
      end
    end else begin
      if (pos_w < 11'(STEP)) begin
        next_pos = '0;
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = 10'(pos_w - 11'(STEP));
      end
    end
  end

endmodule

// File: rtl/logo_motion.sv
// Per-frame logo motion controller: moves the logo once per FRAME_DIV frames at vertical blank start.
//
// state   | meaning
// IDLE    | waiting for vertical blank start (frame divider counting)
// MOVE_X  | new x position visible this cycle
// MOVE_Y  | new y position visible this cycle
// DONE    | update/corner pulse; bounce count already advanced
//
// Each register is loaded on the edge that enters the named state, so x lands one
// cycle after blank start, y two cycles after, and the update pulse on the third.
module logo_motion
  import logo_motion_pkg::*;
#(
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [POS_W-1:0] x_px,
  input  logic [POS_W-1:0] y_px,
  input  logic             run,
  output logic [POS_W-1:0] x_logo,
  output logic [POS_W-1:0] y_logo,
  output logic             dir_x,
  output logic             dir_y,
  output logic             update,
  output logic             corner,
  output logic [7:0]       bounce_cnt
);

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_DIV - 1);

  state_t           state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic             update_q, update_d, corner_q, corner_d;
  logic [7:0]       bounce_q, bounce_d;
  logic [3:0]       frame_q, frame_d;
  logic             in_blank_q, in_blank_d;

  logic [POS_W-1:0] x_nxt, y_nxt;
  logic             dir_x_nxt, dir_y_nxt, hit_x_nxt, hit_y_nxt;
  logic             blank_start;

  // Vertical blank timing depends on the line count alone.
  logic unused_x_px;
  assign unused_x_px = ^x_px;

  assign in_blank_d  = (y_px >= 10'(V_ACTIVE));
  assign blank_start = in_blank_d & ~in_blank_q;

  axis_bounce #(.LIMIT(H_ACTIVE), .SIZE(WIDTH_LOGO), .STEP(STEP_X)) u_axis_x (
    .pos(x_q), .dir(dir_x_q), .next_pos(x_nxt), .next_dir(dir_x_nxt), .hit(hit_x_nxt)
  );

  axis_bounce #(.LIMIT(V_ACTIVE), .SIZE(HEIGHT_LOGO), .STEP(STEP_Y)) u_axis_y (
    .pos(y_q), .dir(dir_y_q), .next_pos(y_nxt), .next_dir(dir_y_nxt), .hit(hit_y_nxt)
  );

  // Next-state and register loads; update/corner default to 0 so they pulse for one cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    hit_x_d  = hit_x_q;
    hit_y_d  = hit_y_q;
    update_d = 1'b0;
    corner_d = 1'b0;
    bounce_d = bounce_q;
    frame_d  = frame_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!run) begin
          frame_d = '0;
        end else if (blank_start) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            x_d     = x_nxt;
            dir_x_d = dir_x_nxt;
            hit_x_d = hit_x_nxt;
            state_d = ST_MOVE_X;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end
      end
      ST_MOVE_X: begin
        y_d     = y_nxt;
        dir_y_d = dir_y_nxt;
        hit_y_d = hit_y_nxt;
        state_d = ST_MOVE_Y;
      end
      ST_MOVE_Y: begin
        update_d = 1'b1;
        corner_d = hit_x_q & hit_y_q;
        if ((hit_x_q | hit_y_q) && bounce_q != 8'hFF) begin
          bounce_d = bounce_q + 8'd1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      x_q        <= 10'(X_INIT);
      y_q        <= 10'(Y_INIT);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      hit_x_q    <= 1'b0;
      hit_y_q    <= 1'b0;
      update_q   <= 1'b0;
      corner_q   <= 1'b0;
      bounce_q   <= '0;
      frame_q    <= '0;
      in_blank_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      hit_x_q    <= hit_x_d;
      hit_y_q    <= hit_y_d;
      update_q   <= update_d;
      corner_q   <= corner_d;
      bounce_q   <= bounce_d;
      frame_q    <= frame_d;
      in_blank_q <= in_blank_d;
    end
  end

  assign x_logo     = x_q;
  assign y_logo     = y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign update     = update_q;
  assign corner     = corner_q;
  assign bounce_cnt = bounce_q;

endmodule
